// File: rtl/forest_sample_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : forest_sample_loader_pkg
//  Description : Shared widths, state encoding and constants for the
//                random-forest sample loader. SAMPLE_W is the same width the
//                tree pipeline register stages use for sampleData.
//  Revision    : 1.0  initial release
// ============================================================================
package forest_sample_loader_pkg;

  localparam int WORD_W    = 32;
  localparam int SAMPLE_W  = 256;
  localparam int BEATS     = SAMPLE_W / WORD_W;
  localparam int NODE_W    = 1;
  localparam int CNT_W     = 16;

  // Every sample enters the forest at the root of tree stage 0.
  localparam int ROOT_NODE = 0;

  // FILL: collecting words into the assembly buffer.
  // FULL: a complete sample waits for the output slot to free up.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage : forest_sample_loader_pkg
`default_nettype wire

// File: rtl/forest_sample_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : forest_sample_loader_if
//  Description : Word-stream input and sample-output bundle of the loader.
//                slave  : the loader side (consumes words, produces samples)
//                master : the producer / pipeline-head side
//  Ports       : word_i, word_valid_i, word_last_i, word_ready_o,
//                sampleData_o, nodeIndex_o, sample_valid_o, sample_ready_i,
//                frame_err_o, sample_count_o
//  Revision    : 1.0  initial release
// ============================================================================
interface forest_sample_loader_if #(
  parameter int WORD_W   = forest_sample_loader_pkg::WORD_W,
  parameter int SAMPLE_W = forest_sample_loader_pkg::SAMPLE_W,
  parameter int NODE_W   = forest_sample_loader_pkg::NODE_W,
  parameter int CNT_W    = forest_sample_loader_pkg::CNT_W
);

  logic [WORD_W-1:0]   word_i;
  logic                word_valid_i;
  logic                word_last_i;
  logic                word_ready_o;
  logic [SAMPLE_W-1:0] sampleData_o;
  logic [NODE_W-1:0]   nodeIndex_o;
  logic                sample_valid_o;
  logic                sample_ready_i;
  logic                frame_err_o;
  logic [CNT_W-1:0]    sample_count_o;

  modport slave (
    input  word_i,
    input  word_valid_i,
    input  word_last_i,
    output word_ready_o,
    output sampleData_o,
    output nodeIndex_o,
    output sample_valid_o,
    input  sample_ready_i,
    output frame_err_o,
    output sample_count_o
  );

  modport master (
    output word_i,
    output word_valid_i,
    output word_last_i,
    input  word_ready_o,
    input  sampleData_o,
    input  nodeIndex_o,
    input  sample_valid_o,
    output sample_ready_i,
    input  frame_err_o,
    input  sample_count_o
  );

endinterface : forest_sample_loader_if
`default_nettype wire

// File: rtl/forest_sample_loader.sv
`default_nettype none
// ============================================================================
//  Module      : forest_sample_loader
//  Description : Write-side front end of the random-forest pipeline. Packs a
//                framed 32-bit word stream little-endian into 256-bit samples
//                and hands each one to tree stage 0 with the root node index
//                over a valid/ready hold handshake.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - forest_sample_loader_if.slave (word stream in,
//                       sample/node out, frame error pulse, sample counter)
//  Revision    : 1.0  initial release
// ============================================================================
module forest_sample_loader
  import forest_sample_loader_pkg::*;
#(
  parameter int WORD_W   = forest_sample_loader_pkg::WORD_W,
  parameter int SAMPLE_W = forest_sample_loader_pkg::SAMPLE_W,
  parameter int NODE_W   = forest_sample_loader_pkg::NODE_W,
  parameter int CNT_W    = forest_sample_loader_pkg::CNT_W
) (
  input  wire                   clk,
  input  wire                   rst,
  forest_sample_loader_if.slave bus
);

  // SAMPLE_W must be an integer multiple of WORD_W.
  localparam int                S_BEATS   = SAMPLE_W / WORD_W;
  localparam int                BEAT_W    = (S_BEATS > 1) ? $clog2(S_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(S_BEATS - 1);

  state_e              state_q,  state_d;
  logic [BEAT_W-1:0]   beat_q,   beat_d;
  logic [SAMPLE_W-1:0] asm_q,    asm_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q,  valid_d;
  logic                err_q,    err_d;
  logic [CNT_W-1:0]    count_q,  count_d;

  logic word_ready;
  logic word_accept;
  logic sample_consume;

  // Ready is forced low during reset so no word is lost across the reset edge.
  assign word_ready     = (state_q == FILL) && !rst;
  assign word_accept    = bus.word_valid_i && word_ready;
  assign sample_consume = valid_q && bus.sample_ready_i;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    asm_d    = asm_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    count_d  = count_q;

    if (sample_consume) begin
      valid_d = 1'b0;
      count_d = count_q + 1'b1;
    end

    case (state_q)
      FILL: begin
        if (word_accept) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (bus.word_last_i) begin
              asm_d[beat_q*WORD_W +: WORD_W] = bus.word_i;
              state_d = FULL;
            end else begin
              // Long frame: drop it; the next word starts a fresh sample.
              err_d = 1'b1;
            end
          end else if (bus.word_last_i) begin
            // Short frame: drop the partial sample. Stale buffer contents are
            // harmless because a complete frame overwrites every beat.
            err_d  = 1'b1;
            beat_d = '0;
          end else begin
            asm_d[beat_q*WORD_W +: WORD_W] = bus.word_i;
            beat_d = beat_q + 1'b1;
          end
        end
      end

      FULL: begin
        // Load into the output slot when it is empty or being drained this
        // cycle; the latter gives back-to-back samples without a bubble.
        if (!valid_q || bus.sample_ready_i) begin
          sample_d = asm_q;
          valid_d  = 1'b1;
          state_d  = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      beat_q   <= '0;
      asm_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      asm_q    <= asm_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign bus.word_ready_o   = word_ready;
  assign bus.sampleData_o   = sample_q;
  assign bus.nodeIndex_o    = NODE_W'(ROOT_NODE);
  assign bus.sample_valid_o = valid_q;
  assign bus.frame_err_o    = err_q;
  assign bus.sample_count_o = count_q;

endmodule : forest_sample_loader
`default_nettype wire

// File: doc/forest_sample_loader.md
Name: forest_sample_loader

Overview:
- Write-side front end of the random-forest classifier pipeline.
- Assembles 256-bit feature samples from a 32-bit word stream using a valid/ready handshake with framing.
- Presents each assembled sample to stage 0 of the tree pipeline together with the root node index.
- Sample output uses a valid/ready hold handshake, so the pipeline head can apply back-pressure.

Parameters:
- WORD_W, 32, input word width; SAMPLE_W must be an integer multiple of it.
- SAMPLE_W, 256, sample width; matches the sampleData width of the pipeline registers.
- NODE_W, 1, width of the stage-0 node index.
- CNT_W, 16, width of the emitted-sample counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- word_i  in  WORD_W  input data word.
- word_valid_i  in  1  word_i is valid.
- word_last_i  in  1  marks the final word of a sample; qualified by word_valid_i.
- word_ready_o  out  1  loader accepts a word this cycle.
- sampleData_o  out  SAMPLE_W  assembled sample to pipeline stage 0.
- nodeIndex_o  out  NODE_W  root node index; constant 0.
- sample_valid_o  out  1  sampleData_o is valid.
- sample_ready_i  in  1  pipeline head accepts the sample.
- frame_err_o  out  1  one-cycle pulse on a framing error.
- sample_count_o  out  CNT_W  number of samples emitted.

Behaviour:
- BEATS = SAMPLE_W/WORD_W (8 at defaults). Beat counter width = clog2(BEATS).
- Reset (rst=1 at a clk edge):
  - state=FILL, beat=0, assembly buffer=0.
  - sampleData_o=0, nodeIndex_o=0, sample_valid_o=0, frame_err_o=0, sample_count_o=0.
  - word_ready_o=0 while rst=1.
  - Reset mid-operation discards any partial or held sample with no error pulse.
- Word accept: occurs when word_valid_i && word_ready_o. word_ready_o = (state==FILL) && !rst.
- Packing is little-endian: beat k writes buffer bits [k*WORD_W +: WORD_W], with beat 0 landing in [31:0].
- State FILL, on each accepted word:
  - beat<BEATS-1 and last=0: write the word; beat++.
  - beat<BEATS-1 and last=1: short frame. frame_err_o=1 next cycle; partial sample dropped; beat=0; stay in FILL.
  - beat==BEATS-1 and last=1: write the word; beat=0; state=FULL.
  - beat==BEATS-1 and last=0: long frame. frame_err_o=1; sample dropped; beat=0; stay in FILL. Subsequent words start a new sample.
- State FULL: word_ready_o=0.
  - When the output slot is free (sample_valid_o==0, or sample_ready_i==1 this cycle), copy the buffer to sampleData_o, set sample_valid_o=1, and return to FILL.
  - Otherwise hold in FULL.
- Output handshake:
  - sample_valid_o stays high and sampleData_o stays stable until sample_valid_o && sample_ready_i.
  - On that cycle, without a simultaneous load, sample_valid_o goes to 0 next cycle.
  - A simultaneous consume and load yields back-to-back valid samples with no bubble.
- sample_count_o increments on each consumed sample (valid && ready) and wraps from 2^CNT_W-1 to 0.
- Latency: from the final-word accept edge to sample_valid_o high is 2 clk edges when the slot is free. The buffer transfers on the edge after entering FULL.
- Throughput: at most 1 sample per BEATS+1 cycles.
- frame_err_o is a single-cycle registered pulse. An error and a FULL->output transfer cannot coincide, because FULL accepts no words.

Decomposition:
- Shared package holds:
  - SAMPLE_W=256, WORD_W=32, BEATS, CNT_W.
  - State enum {FILL, FULL}.
  - ROOT_NODE=0.
  - The same SAMPLE_W is shared with the pipeline register stages.
- No sub-module needed; this is a single FSM plus datapath.

Test Plan:
- Reset, then 8 words 0x11111111..0x88888888 with last on beat 7 and sample_ready_i=1 -> sample_valid_o high 2 cycles after the last accept. sampleData_o=0x88888888_..._11111111, nodeIndex_o=0, sample_count_o=1.
- Short frame: last on beat 3 -> frame_err_o pulses for 1 cycle, no sample_valid_o; the next correct 8-word frame is emitted intact.
- Long frame: beat 7 with last=0 -> frame_err_o pulse; sample dropped; beat counter resynchronises so the next 8-word frame is emitted.
- Back-pressure: sample_ready_i=0 for 20 cycles with a second frame sent behind it -> first sample held stable; loader sits in FULL with word_ready_o=0. On release the two samples are emitted back-to-back; sample_count_o=2.
- Assert rst at beat 5, then release -> all outputs 0, no error pulse; a fresh 8-word frame is emitted correctly.
- Preload the counter path with 65536 consumed samples (or use CNT_W=4 with 16 samples) -> sample_count_o wraps to 0.
